bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single tilelink master port between two requesters: the instruction-fetch agent (IF) and the data agent in the memory-access stage (MA).
- Grants one requester at a time and holds the grant from A-channel acceptance until the D-channel response.
- MA has priority because an MA stall freezes the whole pipeline. A starvation counter guarantees IF progress.
- Sits between the fetch and access stages and the system bus.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive MA grants while IF is waiting; the next grant is forced to IF.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- if_bus  tilelink.slave  -  IF requester: a_valid/a_opcode/a_address/a_data in, a_ready out; d_valid/d_opcode/d_param/d_data out
- ma_bus  tilelink.slave  -  MA requester, same fields as if_bus
- bus  tilelink.master  -  shared downstream port
- grant_if  output  1  IF currently owns the bus
- grant_ma  output  1  MA currently owns the bus
- busy  output  1  a transaction is outstanding (A accepted, D not yet returned)

Behaviour:
- Reset (async, rst_n low): state=IDLE, grant_if=0, grant_ma=0, busy=0, starve_cnt=0. All a_ready and d_valid toward requesters are 0, and bus.a_valid=0.
- States: IDLE, GNT_IF, GNT_MA, WAIT_IF, WAIT_MA.
- IDLE arbitration, decided combinationally and registered into the state on the next edge:
  - only MA valid -> GNT_MA.
  - only IF valid -> GNT_IF.
  - both valid -> GNT_MA, unless starve_cnt==STARVE_LIMIT, in which case -> GNT_IF.
- Minimum latency is one cycle from requester a_valid to bus.a_valid.
- GNT_x:
  - A channel of x is muxed straight to bus: bus.a_valid=x.a_valid and x.a_ready=bus.a_ready. The other requester sees a_ready=0.
  - On bus.a_valid & bus.a_ready -> WAIT_x, busy=1.
  - If x drops a_valid before acceptance -> IDLE with no transfer.
- WAIT_x:
  - A channel is blocked for both requesters: bus.a_valid=0 and both a_ready=0.
  - bus.d_* is routed to x only; the other requester's d_valid is held at 0.
  - On bus.d_valid -> IDLE, grant cleared and busy=0 on the following edge.
- Back-to-back: a new arbitration happens in IDLE only, so there is a one-cycle bubble between transactions. This is accepted for simplicity.
- grant_if is 1 in GNT_IF/WAIT_IF; grant_ma is 1 in GNT_MA/WAIT_MA. Both are registered and never 1 together.
- bus.d_ready is tied to 1; requesters must accept D in the cycle it is presented.
- starve_cnt:
  - +1 when an MA grant is issued while IF a_valid=1, saturating at STARVE_LIMIT.
  - Cleared when an IF grant is issued.
  - Unchanged otherwise.
- D response arriving in the same cycle as A acceptance: illegal on this bus. Not handled; flagged by an assertion.
- Grant changes take effect only in IDLE. A higher-priority request arriving mid-transaction waits; there is no preemption.
- Reset asserted mid-transaction aborts the transaction immediately. Any late D response after reset deassertion is discarded because state=IDLE.

Test Plan:
- Single MA load: ma.a_valid=1 at 0x8000_1000, bus.a_ready=1, d_valid 3 cycles later with data 0xDEAD_BEEF -> grant_ma=1, ma.d_data=0xDEAD_BEEF, if.d_valid=0, IDLE restored.
- Simultaneous IF and MA requests with starve_cnt=0 -> MA served first; IF granted in IDLE after MA's d_valid; starve_cnt goes 0→1→0.
- MA asserted continuously with IF waiting, STARVE_LIMIT=4 -> 4 MA grants, 5th grant to IF; starve_cnt saturates at 4 then clears.
- bus.a_ready held low 5 cycles in GNT_IF while MA requests -> MA a_ready stays 0, no grant switch, IF accepted at cycle 6.
- rst_n pulsed low in WAIT_MA, then a stray d_valid -> all outputs 0 asynchronously; stray D dropped with no d_valid to either requester.
- IF a_valid withdrawn in GNT_IF before a_ready -> return to IDLE, no bus.a_valid & a_ready handshake, starve_cnt unchanged.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-requester arbiter for the shared TileLink master port: MA wins ties,
// a starvation counter forces an IF grant after STARVE_LIMIT back-to-back MA wins.
//
// state   | meaning
// IDLE    | no owner, arbitrate on current a_valid
// GNT_IF  | IF owns A channel, waiting for bus a_ready
// GNT_MA  | MA owns A channel, waiting for bus a_ready
// WAIT_IF | IF request accepted, waiting for D response
// WAIT_MA | MA request accepted, waiting for D response
module bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction-fetch requester
  input  logic              if_a_valid_i,
  input  logic [2:0]        if_a_opcode_i,
  input  logic [ADDR_W-1:0] if_a_address_i,
  input  logic [DATA_W-1:0] if_a_data_i,
  output logic              if_a_ready_o,
  output logic              if_d_valid_o,
  output logic [2:0]        if_d_opcode_o,
  output logic [1:0]        if_d_param_o,
  output logic [DATA_W-1:0] if_d_data_o,
  // memory-access requester
  input  logic              ma_a_valid_i,
  input  logic [2:0]        ma_a_opcode_i,
  input  logic [ADDR_W-1:0] ma_a_address_i,
  input  logic [DATA_W-1:0] ma_a_data_i,
  output logic              ma_a_ready_o,
  output logic              ma_d_valid_o,
  output logic [2:0]        ma_d_opcode_o,
  output logic [1:0]        ma_d_param_o,
  output logic [DATA_W-1:0] ma_d_data_o,
  // shared downstream port
  output logic              bus_a_valid_o,
  output logic [2:0]        bus_a_opcode_o,
  output logic [ADDR_W-1:0] bus_a_address_o,
  output logic [DATA_W-1:0] bus_a_data_o,
  input  logic              bus_a_ready_i,
  input  logic              bus_d_valid_i,
  input  logic [2:0]        bus_d_opcode_i,
  input  logic [1:0]        bus_d_param_i,
  input  logic [DATA_W-1:0] bus_d_data_i,
  output logic              bus_d_ready_o,
  // status
  output logic              grant_if,
  output logic              grant_ma,
  output logic              busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GNT_IF  = 3'd1;
  localparam logic [2:0] GNT_MA  = 3'd2;
  localparam logic [2:0] WAIT_IF = 3'd3;
  localparam logic [2:0] WAIT_MA = 3'd4;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             grant_if_q, grant_ma_q, busy_q;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (ma_a_valid_i && !(if_a_valid_i && starve_q == LIMIT)) begin
          state_d = GNT_MA;
          // only reachable with IF waiting while starve_q < LIMIT, so this saturates
          if (if_a_valid_i) starve_d = starve_q + 1'b1;
        end else if (if_a_valid_i) begin
          state_d  = GNT_IF;
          starve_d = '0;
        end
      end
      GNT_IF: begin
        if (!if_a_valid_i)      state_d = IDLE;
        else if (bus_a_ready_i) state_d = WAIT_IF;
      end
      GNT_MA: begin
        if (!ma_a_valid_i)      state_d = IDLE;
        else if (bus_a_ready_i) state_d = WAIT_MA;
      end
      WAIT_IF, WAIT_MA: begin
        if (bus_d_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      grant_if_q <= 1'b0;
      grant_ma_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      grant_if_q <= (state_d == GNT_IF) || (state_d == WAIT_IF);
      grant_ma_q <= (state_d == GNT_MA) || (state_d == WAIT_MA);
      busy_q     <= (state_d == WAIT_IF) || (state_d == WAIT_MA);
    end
  end

  logic sel_if_a, sel_ma_a, sel_if_d, sel_ma_d;
  assign sel_if_a = (state_q == GNT_IF);
  assign sel_ma_a = (state_q == GNT_MA);
  assign sel_if_d = (state_q == WAIT_IF);
  assign sel_ma_d = (state_q == WAIT_MA);

  assign bus_a_valid_o   = (sel_if_a & if_a_valid_i) | (sel_ma_a & ma_a_valid_i);
  assign bus_a_opcode_o  = sel_ma_a ? ma_a_opcode_i  : if_a_opcode_i;
  assign bus_a_address_o = sel_ma_a ? ma_a_address_i : if_a_address_i;
  assign bus_a_data_o    = sel_ma_a ? ma_a_data_i    : if_a_data_i;
  assign if_a_ready_o    = sel_if_a & bus_a_ready_i;
  assign ma_a_ready_o    = sel_ma_a & bus_a_ready_i;

  assign if_d_valid_o  = sel_if_d & bus_d_valid_i;
  assign if_d_opcode_o = sel_if_d ? bus_d_opcode_i : 3'd0;
  assign if_d_param_o  = sel_if_d ? bus_d_param_i  : 2'd0;
  assign if_d_data_o   = sel_if_d ? bus_d_data_i   : '0;
  assign ma_d_valid_o  = sel_ma_d & bus_d_valid_i;
  assign ma_d_opcode_o = sel_ma_d ? bus_d_opcode_i : 3'd0;
  assign ma_d_param_o  = sel_ma_d ? bus_d_param_i  : 2'd0;
  assign ma_d_data_o   = sel_ma_d ? bus_d_data_i   : '0;
  assign bus_d_ready_o = 1'b1;

  assign grant_if = grant_if_q;
  assign grant_ma = grant_ma_q;
  assign busy     = busy_q;

  // a response in the acceptance cycle would be lost: the bus must never do this
  a_no_d_on_accept: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus_a_valid_o && bus_a_ready_i && bus_d_valid_i));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: an ownership/outstanding model checked every
// negedge, plus hand-computed expectations for each scenario.
module tb_bus_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_a_valid, ma_a_valid, if_a_ready, ma_a_ready;
  logic [2:0]  if_a_opcode, ma_a_opcode, if_d_opcode, ma_d_opcode;
  logic [31:0] if_a_address, ma_a_address, if_a_data, ma_a_data;
  logic        if_d_valid, ma_d_valid;
  logic [1:0]  if_d_param, ma_d_param;
  logic [31:0] if_d_data, ma_d_data;
  logic        bus_a_valid, bus_a_ready, bus_d_valid, bus_d_ready;
  logic [2:0]  bus_a_opcode, bus_d_opcode;
  logic [31:0] bus_a_address, bus_a_data, bus_d_data;
  logic [1:0]  bus_d_param;
  logic        grant_if, grant_ma, busy;

  bus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_a_valid_i(if_a_valid), .if_a_opcode_i(if_a_opcode), .if_a_address_i(if_a_address),
    .if_a_data_i(if_a_data), .if_a_ready_o(if_a_ready), .if_d_valid_o(if_d_valid),
    .if_d_opcode_o(if_d_opcode), .if_d_param_o(if_d_param), .if_d_data_o(if_d_data),
    .ma_a_valid_i(ma_a_valid), .ma_a_opcode_i(ma_a_opcode), .ma_a_address_i(ma_a_address),
    .ma_a_data_i(ma_a_data), .ma_a_ready_o(ma_a_ready), .ma_d_valid_o(ma_d_valid),
    .ma_d_opcode_o(ma_d_opcode), .ma_d_param_o(ma_d_param), .ma_d_data_o(ma_d_data),
    .bus_a_valid_o(bus_a_valid), .bus_a_opcode_o(bus_a_opcode), .bus_a_address_o(bus_a_address),
    .bus_a_data_o(bus_a_data), .bus_a_ready_i(bus_a_ready), .bus_d_valid_i(bus_d_valid),
    .bus_d_opcode_i(bus_d_opcode), .bus_d_param_i(bus_d_param), .bus_d_data_i(bus_d_data),
    .bus_d_ready_o(bus_d_ready),
    .grant_if(grant_if), .grant_ma(grant_ma), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int fires = 0;

  // model: who owns the port (0 none, 1 IF, 2 MA), whether its request is outstanding
  int m_owner = 0;
  bit m_out = 1'b0;
  int m_starve = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner  <= 0;
      m_out    <= 1'b0;
      m_starve <= 0;
    end else if (m_owner == 0) begin
      if (if_a_valid && ma_a_valid) begin
        if (m_starve >= LIMIT) begin
          m_owner  <= 1;
          m_starve <= 0;
        end else begin
          m_owner  <= 2;
          m_starve <= (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end
      end else if (ma_a_valid) begin
        m_owner <= 2;
      end else if (if_a_valid) begin
        m_owner  <= 1;
        m_starve <= 0;
      end
    end else if (!m_out) begin
      if (!((m_owner == 1) ? if_a_valid : ma_a_valid)) m_owner <= 0;
      else if (bus_a_ready) m_out <= 1'b1;
    end else if (bus_d_valid) begin
      m_owner <= 0;
      m_out   <= 1'b0;
    end
  end

  logic e_av, e_idv, e_mdv;
  always @(negedge clk) begin
    e_av  = (m_owner != 0) && !m_out && ((m_owner == 1) ? if_a_valid : ma_a_valid);
    e_idv = (m_owner == 1) && m_out && bus_d_valid;
    e_mdv = (m_owner == 2) && m_out && bus_d_valid;
    chk("grant_if", grant_if, m_owner == 1);
    chk("grant_ma", grant_ma, m_owner == 2);
    chk("busy", busy, m_out);
    chk("bus_a_valid", bus_a_valid, e_av);
    if (e_av) begin
      chk("bus_a_address", bus_a_address, (m_owner == 1) ? if_a_address : ma_a_address);
      chk("bus_a_opcode", bus_a_opcode, (m_owner == 1) ? if_a_opcode : ma_a_opcode);
      chk("bus_a_data", bus_a_data, (m_owner == 1) ? if_a_data : ma_a_data);
    end
    chk("if_a_ready", if_a_ready, (m_owner == 1) && !m_out && bus_a_ready);
    chk("ma_a_ready", ma_a_ready, (m_owner == 2) && !m_out && bus_a_ready);
    chk("if_d_valid", if_d_valid, e_idv);
    chk("ma_d_valid", ma_d_valid, e_mdv);
    if (e_idv) begin
      chk("if_d_data", if_d_data, bus_d_data);
      chk("if_d_opcode", if_d_opcode, bus_d_opcode);
      chk("if_d_param", if_d_param, bus_d_param);
    end
    if (e_mdv) begin
      chk("ma_d_data", ma_d_data, bus_d_data);
      chk("ma_d_opcode", ma_d_opcode, bus_d_opcode);
      chk("ma_d_param", ma_d_param, bus_d_param);
    end
    chk("bus_d_ready", bus_d_ready, 1);
    if (rst_n && bus_a_valid && bus_a_ready) fires++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns just after the edge on which the A handshake completed
  task automatic wait_fire(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (bus_a_valid && bus_a_ready) ok = 1'b1;
      else tick();
    end
    chk(name, ok, 1);
    if (ok) tick();
  endtask

  task automatic serve_d(input logic [31:0] data);
    bus_d_valid  = 1'b1;
    bus_d_data   = data;
    bus_d_opcode = 3'd1;
    bus_d_param  = 2'd0;
    tick();
    bus_d_valid  = 1'b0;
  endtask

  task automatic wait_grant(output int who);
    who = 0;
    for (int k = 0; k < 10 && who == 0; k++) begin
      if (grant_ma) who = 2;
      else if (grant_if) who = 1;
      else tick();
    end
    chk("grant_timeout", who != 0, 1);
  endtask

  int seq[5];
  int who;
  int n_ma_first;
  int f0;

  initial begin
    if_a_valid = 0; if_a_opcode = 3'd4; if_a_address = 32'h0000_0100; if_a_data = 32'h0;
    ma_a_valid = 0; ma_a_opcode = 3'd4; ma_a_address = 32'h8000_1000; ma_a_data = 32'h0;
    bus_a_ready = 0; bus_d_valid = 0; bus_d_opcode = 3'd0; bus_d_param = 2'd0; bus_d_data = 32'h0;

    repeat (2) tick();
    chk("rst_grant_if", grant_if, 0);
    chk("rst_grant_ma", grant_ma, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus_a_valid", bus_a_valid, 0);
    rst_n = 1'b1;
    tick();

    // single MA load
    ma_a_valid = 1; ma_a_address = 32'h8000_1000; bus_a_ready = 1;
    tick();
    chk("t1_grant_ma", grant_ma, 1);
    chk("t1_bus_a_valid", bus_a_valid, 1);
    chk("t1_bus_addr", bus_a_address, 32'h8000_1000);
    tick();
    ma_a_valid = 0;
    chk("t1_busy", busy, 1);
    tick(); tick();
    bus_d_valid = 1; bus_d_data = 32'hDEAD_BEEF; bus_d_opcode = 3'd1;
    #1;
    chk("t1_ma_d_valid", ma_d_valid, 1);
    chk("t1_ma_d_data", ma_d_data, 32'hDEAD_BEEF);
    chk("t1_if_d_valid", if_d_valid, 0);
    tick();
    bus_d_valid = 0;
    chk("t1_idle_grant", grant_ma, 0);
    chk("t1_idle_busy", busy, 0);

    // simultaneous requests, starve 0 -> 1 -> 0
    if_a_valid = 1; if_a_address = 32'h0000_0100;
    ma_a_valid = 1; ma_a_address = 32'h8000_2000; ma_a_opcode = 3'd0; ma_a_data = 32'h0000_1234;
    tick();
    chk("t2_grant_ma", grant_ma, 1);
    chk("t2_grant_if", grant_if, 0);
    chk("t2_starve1", m_starve, 1);
    wait_fire("t2_ma_fire");
    ma_a_valid = 0;
    chk("t2_if_blocked", if_a_ready, 0);
    serve_d(32'h1111_1111);
    chk("t2_bubble", grant_if, 0);
    tick();
    chk("t2_grant_if_after", grant_if, 1);
    chk("t2_starve0", m_starve, 0);
    wait_fire("t2_if_fire");
    if_a_valid = 0;
    serve_d(32'h2222_2222);

    // starvation: four MA grants, fifth to IF
    if_a_valid = 1; ma_a_valid = 1;
    for (int i = 0; i < 5; i++) begin
      wait_grant(who);
      seq[i] = who;
      if (i == 3) chk("t3_starve_sat", m_starve, 4);
      if (who == 1) ma_a_valid = 0;
      wait_fire("t3_fire");
      if (who == 1) if_a_valid = 0;
      serve_d(32'h3000_0000 + i);
    end
    n_ma_first = 0;
    for (int i = 0; i < 5; i++) if (seq[i] == 2 && n_ma_first == i) n_ma_first++;
    chk("t3_ma_grants", n_ma_first, 4);
    chk("t3_fifth_if", seq[4], 1);
    chk("t3_starve_clr", m_starve, 0);

    // IF stalled by bus a_ready, MA must wait
    bus_a_ready = 0; if_a_valid = 1;
    tick();
    chk("t4_grant_if", grant_if, 1);
    ma_a_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_ma_a_ready", ma_a_ready, 0);
      chk("t4_hold_if", grant_if, 1);
      chk("t4_no_ma", grant_ma, 0);
      tick();
    end
    bus_a_ready = 1;
    #1;
    chk("t4_if_a_ready", if_a_ready, 1);
    tick();
    if_a_valid = 0;
    chk("t4_busy", busy, 1);
    serve_d(32'h4444_4444);
    tick();
    chk("t4_ma_next", grant_ma, 1);
    wait_fire("t4_ma_fire");
    ma_a_valid = 0;

    // async reset in WAIT_MA, then a stray response
    chk("t5_in_wait", busy, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t5_async_grant", grant_ma, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_d", ma_d_valid, 0);
    tick();
    rst_n = 1;
    bus_d_valid = 1; bus_d_data = 32'hBAD0_BAD0;
    #1;
    chk("t5_stray_ma", ma_d_valid, 0);
    chk("t5_stray_if", if_d_valid, 0);
    tick();
    bus_d_valid = 0;
    chk("t5_busy", busy, 0);

    // IF withdraws before acceptance
    f0 = fires;
    bus_a_ready = 0; if_a_valid = 1;
    tick();
    chk("t6_grant_if", grant_if, 1);
    tick();
    if_a_valid = 0;
    tick();
    chk("t6_idle", grant_if, 0);
    chk("t6_no_fire", fires, f0);
    chk("t6_starve", m_starve, 0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
